alu_issue_decode: RTL and testbench
===================================

# alu_issue_decode

Instruction-decode/issue stage that feeds the integer ALU. It accepts a fetched RV32I instruction with its PC and register-file read data, and decodes `alu_fn`, `btype`, `bneq`, `operandA`, `operandB` and writeback/memory control. The result is held in a single registered pipeline slot (ID/EX) with valid/ready handshaking and flush. It sits between fetch/register-file read and the execute stage containing the ALU.

## Interface
Parameters
- `XLEN`, 32: datapath width; only 32 is supported.

Ports
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction presented.
- `in_ready` out 1: slot can accept this cycle.
- `instr` in 32: instruction word.
- `pc` in 32: instruction address.
- `rs1_data`, `rs2_data` in 32 each: register-file read data, same cycle as `instr`.
- `flush` in 1: kill the slot (branch taken or trap).
- `out_valid` out 1: slot holds a decoded instruction.
- `out_ready` in 1: execute stage consumes the slot.
- `alu_fn` out 4, `btype` out 1, `bneq` out 1: ALU controls.
- `operandA`, `operandB` out 32: ALU operands.
- `imm` out 32: sign-extended immediate, for branch/jump target.
- `pc_out` out 32, `store_data` out 32 (`rs2_data`).
- `rd` out 5, `rd_we` out 1, `mem_rd` out 1, `mem_wr` out 1, `funct3_out` out 3 (memory size/sign).
- `is_jal` out 1, `is_jalr` out 1, `illegal` out 1.

## Operation
- alu_fn encoding: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub, 1001 sgt, 1010 sgtu, 1101 sra. All other codes are unused.
- OP (0110011): funct3 selects the operation. funct7 0100000 is legal only for funct3 000 (sub) and 101 (sra). Any other funct7 besides 0000000 is illegal. A = rs1, B = rs2.
- OP-IMM (0010011): same mapping, with no sub. A = rs1, B = I-imm.
  - For shifts, B = shamt zero-extended.
  - SLLI requires funct7 0000000. SRLI/SRAI require funct7 0000000/0100000. Any other funct7 is illegal.
- BRANCH (1100011): `btype`=1 and `rd_we`=0. A = rs1, B = rs2.
  - BEQ: 1000, bneq=0. BNE: 1000, bneq=1.
  - BLT: 0010. BLTU: 0011.
  - BGE: 1001. BGEU: 1010 (the ALU treats > or == as taken).
  - funct3 010/011 are illegal.
- LOAD/STORE: alu_fn 0000, A = rs1, B = I-imm (load) or S-imm (store). `mem_rd`/`mem_wr` set. Stores have `rd_we`=0.
- LUI: 0000, A = 0, B = U-imm. AUIPC: 0000, A = pc, B = U-imm.
- JAL: 0000, A = pc, B = J-imm, `is_jal`.
- JALR: 0000, A = rs1, B = I-imm, `is_jalr`. JALR requires funct3 000, otherwise illegal.
- `rd_we` = 0 when rd = x0.
- Illegal or unknown opcode: `illegal`=1, alu_fn 0000, all enables 0, and `out_valid` still asserts so the trap is reported in order.
- `btype` is 0 for all non-branch instructions, and `bneq` is 0 unless BNE.

## Timing
- Latency is one cycle: accepted at edge N, visible on outputs after edge N.
- `in_ready` = !out_valid || out_ready (combinational; one entry, no skid).
- Load when in_valid && in_ready. Otherwise hold all outputs stable while out_valid && !out_ready.
- Consume when out_valid && out_ready with no new load: out_valid goes to 0 next cycle.
- Priority at each edge: rst > flush > load > hold.
- `flush` clears out_valid at the next edge, even if in_valid && in_ready in the same cycle; the incoming instruction is dropped.
- Reset values:
  - out_valid 0, in_ready 1 after reset.
  - alu_fn 0000, all data outputs 0, all flags 0.
- Reset mid-stall discards the held instruction.
- Payload registers may load only on accept, but all flags must read 0 whenever out_valid=0 after reset or flush.

## Structure
- Shared package `rv32_pkg`:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - ALU_* alu_fn constants;
  - funct7 constants.
- Sub-module `imm_gen`: combinational I/S/B/U/J immediate extraction, selected by opcode.
- Top level: decode logic plus the registered slot and handshake.

## Test plan
- ADDI x1,x2,-5 (0xFFB10093), rs1_data=10 → next cycle out_valid=1, alu_fn=0000, A=10, B=0xFFFFFFFB, rd=1, rd_we=1.
- BNE x1,x2,+8 (0x00209463) → alu_fn=1000, btype=1, bneq=1, imm=8, rd_we=0. BGEU → alu_fn=1010, bneq=0.
- SRAI x3,x4,7 (0x40725193) → alu_fn=1101, B=7. Same word with funct7=0100001 → illegal=1, rd_we=0.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs bit-stable. out_ready=1 → next instruction loads on the following edge.
- flush together with in_valid=1 → out_valid=0 next cycle. Instruction 0x00000000 → illegal=1, out_valid=1.
- rst asserted during a stall → out_valid=0, alu_fn=0000, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I opcode, funct7 and ALU function constants plus the
// decoded ID/EX bundle shared by the decode stage.
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SGT  = 4'b1001;
  localparam logic [3:0] ALU_SGTU = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_fn;
    logic        btype;
    logic        bneq;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction; format chosen from the opcode.
// Formats without an immediate yield zero.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [6:0] opc;

  assign opc = instr[6:0];

  always_comb begin
    imm = '0;
    unique case (1'b1)
      (opc == OP_IMM) || (opc == LOAD) || (opc == JALR):
        imm = {{20{instr[31]}}, instr[31:20]};
      opc == STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      opc == BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7],
               instr[30:25], instr[11:8], 1'b0};
      (opc == LUI) || (opc == AUIPC):
        imm = {instr[31:12], 12'b0};
      opc == JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12],
               instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_decode.sv
// RV32I decode/issue stage: decodes ALU controls and operands
// into a single ID/EX slot with valid/ready handshake and flush.
module alu_issue_decode
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_fn,
  output logic            btype,
  output logic            bneq,
  output logic [XLEN-1:0] operandA,
  output logic [XLEN-1:0] operandB,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      funct3_out,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [31:0] imm_w;
  logic        ill;
  logic        accept;
  id_ex_t      dec;
  id_ex_t      slot_d, slot_q;
  logic        valid_d, valid_q;

  assign opc   = instr[6:0];
  assign rd_f  = instr[11:7];
  assign f3    = instr[14:12];
  assign shamt = instr[24:20];
  assign f7    = instr[31:25];

  imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm_w)
  );

  always_comb begin
    dec            = '0;
    ill            = 1'b0;
    dec.pc         = pc;
    dec.store_data = rs2_data;
    dec.imm        = imm_w;
    dec.rd         = rd_f;
    dec.funct3     = f3;
    unique case (1'b1)
      opc == OP: begin
        dec.op_a   = rs1_data;
        dec.op_b   = rs2_data;
        dec.rd_we  = 1'b1;
        dec.alu_fn = {f7[5], f3};
        if (f7 == F7_ALT)
          ill = !((f3 == 3'b000) || (f3 == 3'b101));
        else
          ill = (f7 != F7_BASE);
      end
      opc == OP_IMM: begin
        dec.op_a   = rs1_data;
        dec.op_b   = imm_w;
        dec.rd_we  = 1'b1;
        dec.alu_fn = {1'b0, f3};
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          dec.op_b = {27'b0, shamt};
          if ((f3 == 3'b101) && (f7 == F7_ALT))
            dec.alu_fn = ALU_SRA;
          else
            ill = (f7 != F7_BASE);
        end
      end
      opc == BRANCH: begin
        dec.op_a  = rs1_data;
        dec.op_b  = rs2_data;
        dec.btype = 1'b1;
        unique case (f3)
          3'b000: dec.alu_fn = ALU_SUB;
          3'b001: begin
            dec.alu_fn = ALU_SUB;
            dec.bneq   = 1'b1;
          end
          3'b100: dec.alu_fn = ALU_SLT;
          3'b101: dec.alu_fn = ALU_SGT;
          3'b110: dec.alu_fn = ALU_SLTU;
          3'b111: dec.alu_fn = ALU_SGTU;
          default: ill = 1'b1;
        endcase
      end
      opc == LOAD: begin
        dec.op_a   = rs1_data;
        dec.op_b   = imm_w;
        dec.mem_rd = 1'b1;
        dec.rd_we  = 1'b1;
      end
      opc == STORE: begin
        dec.op_a   = rs1_data;
        dec.op_b   = imm_w;
        dec.mem_wr = 1'b1;
      end
      opc == LUI: begin
        dec.op_b  = imm_w;
        dec.rd_we = 1'b1;
      end
      opc == AUIPC: begin
        dec.op_a  = pc;
        dec.op_b  = imm_w;
        dec.rd_we = 1'b1;
      end
      opc == JAL: begin
        dec.op_a   = pc;
        dec.op_b   = imm_w;
        dec.is_jal = 1'b1;
        dec.rd_we  = 1'b1;
      end
      opc == JALR: begin
        dec.op_a    = rs1_data;
        dec.op_b    = imm_w;
        dec.is_jalr = 1'b1;
        dec.rd_we   = 1'b1;
        ill         = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase
    // A trap carries no side effects, only the report itself.
    if (ill) begin
      dec.alu_fn  = ALU_ADD;
      dec.op_a    = '0;
      dec.op_b    = '0;
      dec.btype   = 1'b0;
      dec.bneq    = 1'b0;
      dec.rd_we   = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.is_jal  = 1'b0;
      dec.is_jalr = 1'b0;
    end
    if (rd_f == 5'd0)
      dec.rd_we = 1'b0;
    dec.illegal = ill;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      slot_d  = dec;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  // Flags are qualified by valid so a flushed slot reads clean.
  assign out_valid  = valid_q;
  assign alu_fn     = slot_q.alu_fn;
  assign operandA   = slot_q.op_a;
  assign operandB   = slot_q.op_b;
  assign imm        = slot_q.imm;
  assign pc_out     = slot_q.pc;
  assign store_data = slot_q.store_data;
  assign rd         = slot_q.rd;
  assign funct3_out = slot_q.funct3;
  assign btype      = slot_q.btype   & valid_q;
  assign bneq       = slot_q.bneq    & valid_q;
  assign rd_we      = slot_q.rd_we   & valid_q;
  assign mem_rd     = slot_q.mem_rd  & valid_q;
  assign mem_wr     = slot_q.mem_wr  & valid_q;
  assign is_jal     = slot_q.is_jal  & valid_q;
  assign is_jalr    = slot_q.is_jalr & valid_q;
  assign illegal    = slot_q.illegal & valid_q;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Scoreboard bench for alu_issue_decode: driver queues expected
// decodes, a negedge monitor compares each consumed slot.
module tb_alu_issue_decode;

  typedef struct packed {
    logic [3:0]  alu_fn;
    logic        btype;
    logic        bneq;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  f3;
    logic        jal;
    logic        jalr;
    logic        ill;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
    obs_t  m;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  alu_fn;
  logic        btype, bneq;
  logic [31:0] operandA, operandB, imm, pc_out, store_data;
  logic [4:0]  rd;
  logic        rd_we, mem_rd, mem_wr;
  logic [2:0]  funct3_out;
  logic        is_jal, is_jalr, illegal;

  int   checks = 0;
  int   failures = 0;
  sb_t  q[$];
  obs_t cur;

  always #5 clk = ~clk;

  alu_issue_decode #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_fn     (alu_fn),
    .btype      (btype),
    .bneq       (bneq),
    .operandA   (operandA),
    .operandB   (operandB),
    .imm        (imm),
    .pc_out     (pc_out),
    .store_data (store_data),
    .rd         (rd),
    .rd_we      (rd_we),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .funct3_out (funct3_out),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .illegal    (illegal)
  );

  assign cur = {alu_fn, btype, bneq, operandA, operandB, imm,
                pc_out, store_data, rd, rd_we, mem_rd, mem_wr,
                funct3_out, is_jal, is_jalr, illegal};

  task automatic chk(string nm, logic [179:0] act, logic [179:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic obs_t mk(logic [31:0] p, logic [31:0] sd,
                              logic [4:0] r, logic [2:0] f);
    obs_t o;
    o    = '0;
    o.pc = p;
    o.sd = sd;
    o.rd = r;
    o.f3 = f;
    return o;
  endfunction

  function automatic obs_t mask_ill();
    obs_t m;
    m     = '1;
    m.a   = '0;
    m.b   = '0;
    m.imm = '0;
    m.rd  = '0;
    return m;
  endfunction

  function automatic obs_t mask_rtype();
    obs_t m;
    m     = '1;
    m.imm = '0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {148'd0, cur.pc}, 180'd0);
      end else begin
        sb_t s;
        s = q.pop_front();
        chk(s.nm, cur & s.m, s.e & s.m);
      end
    end
  end

  task automatic issue(string nm, logic [31:0] i, logic [31:0] p,
                       logic [31:0] r1, logic [31:0] r2,
                       obs_t e, obs_t m, bit push);
    int n;
    sb_t s;
    n        = 0;
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 180'(in_ready), 180'd1);
    end else if (push) begin
      s.nm = nm;
      s.e  = e;
      s.m  = m;
      q.push_back(s);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    obs_t full;
    obs_t snap;
    full = '1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 180'(out_valid), 180'd0);
    chk("rst_in_ready", 180'(in_ready), 180'd1);
    chk("rst_outputs", cur, 180'd0);
    @(posedge clk);
    #1;

    e = mk(32'h100, 32'd3, 5'd1, 3'd0);
    e.a = 32'd10; e.b = 32'hFFFFFFFB; e.imm = 32'hFFFFFFFB;
    e.rd_we = 1'b1;
    issue("addi", 32'hFFB10093, 32'h100, 32'd10, 32'd3, e, full, 1);

    e = mk(32'h104, 32'd7, 5'd8, 3'd1);
    e.alu_fn = 4'b1000; e.btype = 1'b1; e.bneq = 1'b1;
    e.a = 32'd5; e.b = 32'd7; e.imm = 32'd8;
    issue("bne", 32'h00209463, 32'h104, 32'd5, 32'd7, e, full, 1);

    e = mk(32'h108, 32'd7, 5'd8, 3'd7);
    e.alu_fn = 4'b1010; e.btype = 1'b1;
    e.a = 32'd5; e.b = 32'd7; e.imm = 32'd8;
    issue("bgeu", 32'h0020F463, 32'h108, 32'd5, 32'd7, e, full, 1);

    e = mk(32'h10C, 32'd0, 5'd3, 3'd5);
    e.alu_fn = 4'b1101; e.a = 32'h80000000; e.b = 32'd7;
    e.imm = 32'h407; e.rd_we = 1'b1;
    issue("srai", 32'h40725193, 32'h10C, 32'h80000000, 32'd0,
          e, full, 1);

    e = mk(32'h110, 32'd2, 5'd3, 3'd5);
    e.ill = 1'b1;
    issue("srai_bad_f7", 32'h42725193, 32'h110, 32'd1, 32'd2,
          e, mask_ill(), 1);

    e = mk(32'h114, 32'h22, 5'd5, 3'd0);
    e.a = 32'h11; e.b = 32'h22; e.rd_we = 1'b1;
    issue("add", 32'h007302B3, 32'h114, 32'h11, 32'h22,
          e, mask_rtype(), 1);

    e.pc = 32'h118; e.alu_fn = 4'b1000;
    issue("sub", 32'h407302B3, 32'h118, 32'h11, 32'h22,
          e, mask_rtype(), 1);

    e = mk(32'h11C, 32'd9, 5'd8, 3'd2);
    e.a = 32'h1000; e.b = 32'd12; e.imm = 32'd12;
    e.rd_we = 1'b1; e.mem_rd = 1'b1;
    issue("lw", 32'h00C4A403, 32'h11C, 32'h1000, 32'd9, e, full, 1);

    e = mk(32'h120, 32'hDEADBEEF, 5'd28, 3'd2);
    e.a = 32'h2000; e.b = 32'hFFFFFFFC; e.imm = 32'hFFFFFFFC;
    e.mem_wr = 1'b1;
    issue("sw", 32'hFE74AE23, 32'h120, 32'h2000, 32'hDEADBEEF,
          e, full, 1);

    e = mk(32'h124, 32'd0, 5'd10, 3'd5);
    e.b = 32'h12345000; e.imm = 32'h12345000; e.rd_we = 1'b1;
    issue("lui", 32'h12345537, 32'h124, 32'h55, 32'd0, e, full, 1);

    e = mk(32'h128, 32'd0, 5'd11, 3'd1);
    e.a = 32'h128; e.b = 32'h1000; e.imm = 32'h1000;
    e.rd_we = 1'b1;
    issue("auipc", 32'h00001597, 32'h128, 32'h55, 32'd0, e, full, 1);

    e = mk(32'h12C, 32'd0, 5'd1, 3'd0);
    e.a = 32'h12C; e.b = 32'd16; e.imm = 32'd16;
    e.rd_we = 1'b1; e.jal = 1'b1;
    issue("jal", 32'h010000EF, 32'h12C, 32'h55, 32'd0, e, full, 1);

    e = mk(32'h130, 32'd0, 5'd0, 3'd0);
    e.a = 32'h400; e.jalr = 1'b1;
    issue("jalr_x0", 32'h00008067, 32'h130, 32'h400, 32'd0,
          e, full, 1);

    e = mk(32'h134, 32'd0, 5'd0, 3'd0);
    e.ill = 1'b1;
    issue("zero_word", 32'h00000000, 32'h134, 32'h1, 32'd0,
          e, mask_ill(), 1);

    repeat (2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    e = mk(32'h200, 32'h5, 5'd5, 3'd0);
    e.a = 32'h3; e.b = 32'h5; e.rd_we = 1'b1;
    issue("stall_add", 32'h007302B3, 32'h200, 32'h3, 32'h5,
          e, mask_rtype(), 1);
    in_valid = 1'b1;
    instr    = 32'h407302B3;
    pc       = 32'h204;
    rs1_data = 32'h9;
    rs2_data = 32'h4;
    @(negedge clk);
    snap = cur;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_in_ready", 180'(in_ready), 180'd0);
      chk("stall_out_valid", 180'(out_valid), 180'd1);
      chk("stall_stable", cur, snap);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    e = mk(32'h204, 32'h4, 5'd5, 3'd0);
    e.alu_fn = 4'b1000; e.a = 32'h9; e.b = 32'h4; e.rd_we = 1'b1;
    issue("after_stall_sub", 32'h407302B3, 32'h204, 32'h9, 32'h4,
          e, mask_rtype(), 1);
    repeat (2) @(posedge clk);
    #1;

    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'hFFB10093;
    pc       = 32'h300;
    rs1_data = 32'd10;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 180'(out_valid), 180'd0);
    chk("flush_rd_we", 180'(rd_we), 180'd0);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    issue("rst_victim", 32'h40725193, 32'h400, 32'h1, 32'h0,
          full, full, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall_out_valid", 180'(out_valid), 180'd0);
    chk("rst_stall_alu_fn", 180'(alu_fn), 180'd0);
    chk("rst_stall_in_ready", 180'(in_ready), 180'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 180'(q.size()), 180'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
